// File: rtl/spi_pkg.sv
// Shared constants for the SPI input conditioner: pin idle levels and
// debounce-length limits.
package spi_pkg;

    localparam int unsigned WAIT_DEFAULT = 3;
    localparam int unsigned WAIT_MAX     = 15;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_ic_channel.sv
// One conditioning channel: two-flop synchronizer, optional debounce filter
// and registered edge strobes. The debounce filter is built only when
// SPI_IC_DEBOUNCE_EN is defined; otherwise the synchronized level passes
// straight through one register and WAIT has no effect.
module spi_ic_channel
    import spi_pkg::*;
#(
    parameter int unsigned WAIT = WAIT_DEFAULT,
    parameter logic        IDLE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic cond,
    output logic pos,
    output logic neg
);

    if (WAIT < 1 || WAIT > WAIT_MAX) begin : g_bad_wait
        $error("spi_ic_channel: WAIT out of range 1..15");
    end

    logic s1;
    logic s2;

    // Two-flop synchronizer; resets to the channel idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= IDLE;
            s2 <= IDLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef SPI_IC_DEBOUNCE_EN
    localparam int unsigned    CW   = $clog2(WAIT + 1);
    localparam logic [CW-1:0]  LAST = CW'(WAIT - 1);

    logic [CW-1:0] cnt;

    // Accept a new level only after WAIT consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            cond <= IDLE;
            pos  <= 1'b0;
            neg  <= 1'b0;
        end else begin
            pos <= 1'b0;
            neg <= 1'b0;
            if (s2 == cond) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cond <= s2;
                cnt  <= '0;
                pos  <= s2;
                neg  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    // Unfiltered: follow the synchronized level and strobe on every change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond <= IDLE;
            pos  <= 1'b0;
            neg  <= 1'b0;
        end else begin
            cond <= s2;
            pos  <= s2 & ~cond;
            neg  <= ~s2 & cond;
        end
    end
`endif

endmodule

// File: rtl/spi_input_conditioner.sv
// Conditions the raw SPI pins (sclk, cs, mosi) into the clk domain.
// Three independent spi_ic_channel instances; debounce filtering is
// enabled by defining SPI_IC_DEBOUNCE_EN.
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int unsigned WAIT = WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic sclk_cond,
    output logic sclk_pos,
    output logic sclk_neg,
    output logic cs_cond,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_cond
);

    logic unused_mosi_pos;
    logic unused_mosi_neg;

    spi_ic_channel #(.WAIT(WAIT), .IDLE(SCLK_IDLE)) u_sclk (
        .clk   (clk),
        .reset (reset),
        .raw   (sclk_in),
        .cond  (sclk_cond),
        .pos   (sclk_pos),
        .neg   (sclk_neg)
    );

    // cs is active-low: leaving idle (1->0) is the frame-start strobe.
    spi_ic_channel #(.WAIT(WAIT), .IDLE(CS_IDLE)) u_cs (
        .clk   (clk),
        .reset (reset),
        .raw   (cs_in),
        .cond  (cs_cond),
        .pos   (cs_rise),
        .neg   (cs_fall)
    );

    spi_ic_channel #(.WAIT(WAIT), .IDLE(MOSI_IDLE)) u_mosi (
        .clk   (clk),
        .reset (reset),
        .raw   (mosi_in),
        .cond  (mosi_cond),
        .pos   (unused_mosi_pos),
        .neg   (unused_mosi_neg)
    );

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Self-checking bench for spi_input_conditioner (WAIT=3). Expectations
// follow SPI_IC_DEBOUNCE_EN in the same way as the design.
module tb_spi_input_conditioner;

    localparam int unsigned WAIT = 3;
`ifdef SPI_IC_DEBOUNCE_EN
    localparam bit          FILT = 1'b1;
    localparam int unsigned LAT  = WAIT + 2;
`else
    localparam bit          FILT = 1'b0;
    localparam int unsigned LAT  = 3;
`endif
    // {sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, cs_rise, mosi_cond}
    localparam logic [6:0] IDLE_OUT = 7'b0001000;

    logic clk;
    logic reset;
    logic sclk_in, cs_in, mosi_in;
    logic sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, cs_rise, mosi_cond;

    spi_input_conditioner #(.WAIT(WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk_in   (sclk_in),
        .cs_in     (cs_in),
        .mosi_in   (mosi_in),
        .sclk_cond (sclk_cond),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .cs_cond   (cs_cond),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi_cond (mosi_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] outv();
        return {sclk_cond, sclk_pos, sclk_neg, cs_cond, cs_fall, cs_rise, mosi_cond};
    endfunction

    // ---------------- reference model ----------------
    // Conditioned level = synchronized pin delayed two edges; with the filter
    // a change is accepted once it has disagreed for WAIT edges in a row.
    localparam logic IDLE_LVL [3] = '{1'b0, 1'b1, 1'b0};
    logic        log_r [3][4096];
    int unsigned n_edge;
    logic        m_cond [3];
    int          m_run  [3];
    logic        m_lead [3];
    logic        m_ret  [3];
    bit          chk_en = 1'b0;

    function automatic logic pin(int c);
        case (c)
            0:       return sclk_in;
            1:       return cs_in;
            default: return mosi_in;
        endcase
    endfunction

    always begin
        @(posedge clk);
        if (reset) begin
            n_edge = 0;
            for (int c = 0; c < 3; c++) begin
                m_cond[c] = IDLE_LVL[c];
                m_run[c]  = 0;
                m_lead[c] = 1'b0;
                m_ret[c]  = 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                logic seen, old;
                log_r[c][n_edge % 4096] = pin(c);
                seen = (n_edge >= 2) ? log_r[c][(n_edge - 2) % 4096] : IDLE_LVL[c];
                old  = m_cond[c];
                if (FILT) begin
                    m_run[c] = (seen != old) ? m_run[c] + 1 : 0;
                    if (m_run[c] == int'(WAIT)) begin
                        m_cond[c] = seen;
                        m_run[c]  = 0;
                    end
                end else begin
                    m_cond[c] = seen;
                end
                m_lead[c] = (old == IDLE_LVL[c]) && (m_cond[c] != IDLE_LVL[c]);
                m_ret[c]  = (old != IDLE_LVL[c]) && (m_cond[c] == IDLE_LVL[c]);
            end
            n_edge++;
        end
        #1;
        if (chk_en)
            check("model", {25'd0, outv()},
                  {25'd0, m_cond[0], m_lead[0], m_ret[0], m_cond[1], m_lead[1], m_ret[1], m_cond[2]});
    end

    // ---------------- directed helpers ----------------
    int   cyc, npos, nneg, nfall, nrise, first_pos, last_pos, fall_cyc, rise_cyc;
    bit   sclk_hi_seen;
    logic [15:0] cap;

    task automatic clear_stats();
        npos = 0; nneg = 0; nfall = 0; nrise = 0;
        first_pos = -1; last_pos = -1; fall_cyc = -1; rise_cyc = -1;
        sclk_hi_seen = 1'b0; cap = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sclk_pos) begin
            npos++;
            cap = {cap[14:0], mosi_cond};
            if (first_pos < 0) first_pos = cyc;
            last_pos = cyc;
        end
        if (sclk_neg) nneg++;
        if (cs_fall) begin nfall++; fall_cyc = cyc; end
        if (cs_rise) begin nrise++; rise_cyc = cyc; end
        if (sclk_cond) sclk_hi_seen = 1'b1;
    endtask

    typedef struct {
        logic       sclk;
        logic       cs;
        logic       mosi;
        logic [6:0] exp;
    } vec_t;
    vec_t vt[$];

    // Pulse of p cycles on channel ch away from idle, plus enough settle time.
    task automatic add_pulse(input int ch, input int p);
        bit acc;
        acc = FILT ? (p >= int'(WAIT)) : 1'b1;
        for (int k = 0; k < p + int'(LAT) + 4; k++) begin
            vec_t v;
            logic on, lead, ret;
            on   = acc && (k >= int'(LAT)) && (k < p + int'(LAT));
            lead = acc && (k == int'(LAT));
            ret  = acc && (k == p + int'(LAT));
            v.sclk = (ch == 0) ? (k < p) : 1'b0;
            v.cs   = (ch == 1) ? !(k < p) : 1'b1;
            v.mosi = (ch == 2) ? (k < p) : 1'b0;
            v.exp  = IDLE_OUT;
            if (ch == 0) v.exp[6:4] = {on, lead, ret};
            if (ch == 1) v.exp[3:1] = {!on, lead, ret};
            if (ch == 2) v.exp[0]   = on;
            vt.push_back(v);
        end
    endtask

    initial begin
        int hold [3];
        logic [15:0] frame;

        cyc = 0;
        clear_stats();

        // Reset with random pins
        reset = 1'b1;
        {sclk_in, cs_in, mosi_in} = 3'($urandom);
        repeat (3) @(posedge clk);
        #1 check("reset_idle", {25'd0, outv()}, {25'd0, IDLE_OUT});
        {sclk_in, cs_in, mosi_in} = 3'($urandom);
        @(posedge clk);
        #1 check("reset_idle2", {25'd0, outv()}, {25'd0, IDLE_OUT});
        sclk_in = 1'b0; cs_in = 1'b1; mosi_in = 1'b0;
        #2 reset = 1'b0;
        repeat (6) tick();

        // Table: latency, glitch rejection, boundary pulse lengths
        add_pulse(0, 10);
        add_pulse(1, 2);
        add_pulse(1, 3);
        add_pulse(2, 4);
        add_pulse(0, 1);
        add_pulse(0, 2);
        add_pulse(0, 3);
        for (int k = 0; k < vt.size(); k++) begin
            tick();
            check($sformatf("vec%0d", k), {25'd0, outv()}, {25'd0, vt[k].exp});
            sclk_in = vt[k].sclk;
            cs_in   = vt[k].cs;
            mosi_in = vt[k].mosi;
        end

        // Full frame: 0xA5 0x3C, MSB first, 8-cycle sclk periods
        repeat (4) tick();
        clear_stats();
        frame = 16'hA53C;
        cs_in = 1'b0;
        repeat (6) tick();
        for (int i = 15; i >= 0; i--) begin
            mosi_in = frame[i];
            sclk_in = 1'b0;
            repeat (4) tick();
            sclk_in = 1'b1;
            repeat (4) tick();
        end
        sclk_in = 1'b0;
        repeat (4) tick();
        cs_in = 1'b1;
        mosi_in = 1'b0;
        repeat (10) tick();
        check("frame_npos", npos, 16);
        check("frame_data", {16'd0, cap}, {16'd0, frame});
        check("frame_fall_first", {31'd0, fall_cyc >= 0 && fall_cyc < first_pos}, 32'd1);
        check("frame_rise_last", {31'd0, rise_cyc > last_pos}, 32'd1);
        check("frame_cs_strobes", nfall * 16 + nrise, 17);

        // Fast sclk: toggling every 2 cycles
        clear_stats();
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) sclk_in = ~sclk_in;
            tick();
        end
        repeat (8) tick();
        check("fast_strobes", npos + nneg, FILT ? 0 : 20);
        check("fast_cond_high", {31'd0, sclk_hi_seen}, FILT ? 32'd0 : 32'd1);

        // Async reset mid-frame
        cs_in = 1'b0; sclk_in = 1'b1; mosi_in = 1'b1;
        repeat (12) tick();
        check("pre_reset", {25'd0, outv()}, {25'd0, 7'b1000001});
        #2 reset = 1'b1;
        #1 check("async_reset", {25'd0, outv()}, {25'd0, IDLE_OUT});
        sclk_in = 1'b0; cs_in = 1'b1; mosi_in = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("reset_exit%0d", k), {25'd0, outv()}, {25'd0, IDLE_OUT});
        end

        // Randomized run against the model
        for (int c = 0; c < 3; c++) hold[c] = 0;
        chk_en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    hold[c] = $urandom_range(1, 6);
                    case (c)
                        0:       sclk_in = ~sclk_in;
                        1:       cs_in   = ~cs_in;
                        default: mosi_in = ~mosi_in;
                    endcase
                end else begin
                    hold[c]--;
                end
            end
        end
        tick();
        chk_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
